reg_access_ctrl: RTL and testbench

Command-driven initiator for the 16x8 register_unit. Accepts read, write, dump-all and clear-all commands over a valid/ready command port and drives register_unit's load/addr/data_in pins. Samples register_unit's data_out and returns read data over a valid/ready response port. Sits between a CPU/control FSM and register_unit, replacing ad-hoc direct pin toggling.

---
 rtl/reg_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
// Command-driven initiator for a 2**ADDR_W x DATA_W register unit: executes read, write,
// dump-all and clear-all commands and returns read data over a valid/ready response port.
module reg_access_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              reg_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StResp,
        StDumpRd,
        StDumpResp,
        StClear
    } state_e;

    localparam logic [ADDR_W-1:0] LastIdx = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] index_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              rsp_valid_q;
    logic [ADDR_W-1:0] rsp_addr_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_last_q;
    logic              reg_load_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0] reg_wdata_q;

    // All outputs are registered so they change only with the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            index_q     <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            reg_load_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        index_q     <= '0;
                        case (cmd_op)
                            2'b00: begin
                                state_q    <= StRead;
                                reg_addr_q <= cmd_addr;
                            end
                            2'b01: begin
                                state_q     <= StWrite;
                                reg_load_q  <= 1'b1;
                                reg_addr_q  <= cmd_addr;
                                reg_wdata_q <= cmd_wdata;
                            end
                            2'b10: begin
                                state_q    <= StDumpRd;
                                reg_addr_q <= '0;
                            end
                            default: begin
                                state_q     <= StClear;
                                reg_load_q  <= 1'b1;
                                reg_addr_q  <= '0;
                                reg_wdata_q <= '0;
                            end
                        endcase
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                StWrite: begin
                    state_q     <= StIdle;
                    reg_load_q  <= 1'b0;
                    reg_addr_q  <= '0;
                    reg_wdata_q <= '0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                StRead: begin
                    rsp_data_q  <= reg_rdata;
                    rsp_addr_q  <= reg_addr_q;
                    rsp_last_q  <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    reg_addr_q  <= '0;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StDumpRd: begin
                    rsp_data_q  <= reg_rdata;
                    rsp_addr_q  <= index_q;
                    rsp_last_q  <= (index_q == LastIdx);
                    rsp_valid_q <= 1'b1;
                    state_q     <= StDumpResp;
                end
                StDumpResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            index_q     <= '0;
                            reg_addr_q  <= '0;
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            index_q    <= index_q + ADDR_W'(1);
                            reg_addr_q <= index_q + ADDR_W'(1);
                            state_q    <= StDumpRd;
                        end
                    end
                end
                StClear: begin
                    if (index_q == LastIdx) begin
                        index_q     <= '0;
                        reg_load_q  <= 1'b0;
                        reg_addr_q  <= '0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        index_q    <= index_q + ADDR_W'(1);
                        reg_addr_q <= index_q + ADDR_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign reg_load  = reg_load_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed-plus-random bench for reg_access_ctrl with a behavioural register-unit and an
// expected-contents model updated from command semantics.
module tb_reg_access_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_addr = 4'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic       reg_load;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mem [16] = '{default: 8'h00};
    bit   [7:0] exp_mem [16];

    always #5 clock = ~clock;

    assign reg_rdata = mem[reg_addr];
    always @(posedge clock) if (reg_load === 1'b1) mem[reg_addr] <= reg_wdata;

    reg_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_addr (rsp_addr),
        .rsp_data (rsp_data),
        .rsp_last (rsp_last),
        .busy     (busy),
        .reg_load (reg_load),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_reg_load"}, 32'(reg_load), 32'd0);
        chk({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        chk("cmd_accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 4'd0;
        cmd_wdata = 8'd0;
        @(negedge clock);
    endtask

    task automatic take_rsp(input logic [3:0] ea, input logic [7:0] ed, input logic el,
                            input int stall);
        int t = 0;
        while (rsp_valid !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_addr", 32'(rsp_addr), 32'(ea));
        chk("rsp_data", 32'(rsp_data), 32'(ed));
        chk("rsp_last", 32'(rsp_last), 32'(el));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(ed));
            chk("stall_addr", 32'(rsp_addr), 32'(ea));
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_reg_load", 32'(reg_load), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        send_cmd(2'd1, a, d);
        chk("wr_load", 32'(reg_load), 32'd1);
        chk("wr_addr", 32'(reg_addr), 32'(a));
        chk("wr_data", 32'(reg_wdata), 32'(d));
        chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        @(negedge clock);
        chk("wr_load_end", 32'(reg_load), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);
        exp_mem[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a, input int stall);
        send_cmd(2'd0, a, 8'h00);
        chk("rd_not_yet", 32'(rsp_valid), 32'd0);
        chk("rd_no_load", 32'(reg_load), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        @(negedge clock);
        chk("rd_latency", 32'(rsp_valid), 32'd1);
        take_rsp(a, exp_mem[a], 1'b1, stall);
        chk("rd_ready_again", 32'(cmd_ready), 32'd1);
    endtask

    // mode 0: alternate stall, 1: random stall
    task automatic do_dump(input int mode);
        send_cmd(2'd2, 4'd0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            take_rsp(4'(i), exp_mem[i], (i == 15), (mode == 0) ? (i % 2) :
                     int'($urandom_range(0, 3)));
        end
        chk("dump_idle", 32'(busy), 32'd0);
        chk("dump_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // Asynchronous reset asserted mid-cycle.
        @(negedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_async");
        @(negedge clock);
        reset = 1'b0;
        chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        chk("ready_after_edge", 32'(cmd_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        do_write(4'd1, 8'h04);
        do_write(4'd2, 8'h05);
        do_read(4'd1, 0);
        do_read(4'd2, 0);
        do_read(4'd3, 0);
        do_read(4'd2, 5);

        for (int i = 0; i < 16; i++) do_write(4'(i), 8'(8'h10 + i));
        do_dump(0);

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            else
                do_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
        do_dump(1);

        // Clear: sixteen consecutive load cycles writing zero in ascending order.
        send_cmd(2'd3, 4'd9, 8'hAA);
        for (int i = 0; i < 16; i++) begin
            chk("clr_load", 32'(reg_load), 32'd1);
            chk("clr_addr", 32'(reg_addr), 32'(i));
            chk("clr_data", 32'(reg_wdata), 32'd0);
            chk("clr_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clock);
        end
        chk("clr_load_end", 32'(reg_load), 32'd0);
        chk("clr_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        do_dump(1);

        for (int k = 0; k < 6; k++)
            do_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));

        // Reset while the dump is presenting index 7.
        send_cmd(2'd2, 4'd0, 8'h00);
        for (int i = 0; i < 7; i++) take_rsp(4'(i), exp_mem[i], 1'b0, i % 2);
        for (int t = 0; t < 10 && rsp_valid !== 1'b1; t++) @(negedge clock);
        chk("abort_at_idx", 32'(rsp_addr), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid_dump");
        @(negedge clock);
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("post_abort_valid", 32'(rsp_valid), 32'd0);
            chk("post_abort_busy", 32'(busy), 32'd0);
            chk("post_abort_load", 32'(reg_load), 32'd0);
        end
        rsp_ready = 1'b0;
        chk("post_abort_ready", 32'(cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
